// File: rtl/memory_sequence_controller.sv
// Memory-stage sequencer for stack ops, call/return and interrupt entry/exit.
// Tracks stack depth and raises a sticky error on overflow or underflow.
module memory_sequence_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic        int_req,
    output logic        op_ready,
    output logic        stall,
    output logic        memory_read,
    output logic        memory_write,
    output logic        memory_push,
    output logic        memory_pop,
    output logic [1:0]  memory_address_select,
    output logic [1:0]  memory_write_src_select,
    output logic        pc_choose_memory,
    output logic        interrupt,
    output logic        flags_restore,
    output logic [10:0] stack_depth,
    output logic        stack_error
);

    typedef enum logic [3:0] {
        IDLE,
        CALL_LO,
        RET_HI,
        RET_PC,
        INT_HI,
        INT_LO,
        INT_FL,
        INT_JMP,
        RTI_LO,
        RTI_HI,
        RTI_PC
    } state_e;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDD  = 3'b001;
    localparam logic [2:0] OP_STD  = 3'b010;
    localparam logic [2:0] OP_PUSH = 3'b011;
    localparam logic [2:0] OP_POP  = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;
    localparam logic [2:0] OP_RTI  = 3'b111;

    localparam logic [1:0] ADDR_STD = 2'b00;
    localparam logic [1:0] ADDR_LDD = 2'b01;
    localparam logic [1:0] ADDR_SP  = 2'b10;

    localparam logic [1:0] SRC_FLAGS = 2'b00;
    localparam logic [1:0] SRC_PC_HI = 2'b01;
    localparam logic [1:0] SRC_PC_LO = 2'b10;
    localparam logic [1:0] SRC_REG   = 2'b11;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic [10:0] depth_q, depth_d;
    logic        err_q, err_d;

    always_comb begin
        state_d                 = state_q;
        pend_d                  = pend_q | int_req;
        err_d                   = err_q;
        op_ready                = 1'b0;
        stall                   = 1'b0;
        memory_read             = 1'b0;
        memory_write            = 1'b0;
        memory_push             = 1'b0;
        memory_pop              = 1'b0;
        memory_address_select   = ADDR_STD;
        memory_write_src_select = SRC_FLAGS;
        pc_choose_memory        = 1'b0;
        interrupt               = 1'b0;
        flags_restore           = 1'b0;

        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        // Pending interrupt wins over any new op.
                        stall  = 1'b1;
                        pend_d = 1'b0;
                        if (depth_q <= 11'd1021) state_d = INT_HI;
                        else                     err_d   = 1'b1;
                    end else begin
                        op_ready = 1'b1;
                        if (op_valid) begin
                            unique case (op_code)
                                OP_NOP: ;
                                OP_LDD: begin
                                    memory_read           = 1'b1;
                                    memory_address_select = ADDR_LDD;
                                end
                                OP_STD: begin
                                    memory_write            = 1'b1;
                                    memory_write_src_select = SRC_REG;
                                end
                                OP_PUSH: begin
                                    if (depth_q <= 11'd1023) begin
                                        memory_write            = 1'b1;
                                        memory_push             = 1'b1;
                                        memory_address_select   = ADDR_SP;
                                        memory_write_src_select = SRC_REG;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                OP_POP: begin
                                    if (depth_q >= 11'd1) begin
                                        memory_read           = 1'b1;
                                        memory_pop            = 1'b1;
                                        memory_address_select = ADDR_SP;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                OP_CALL: begin
                                    if (depth_q <= 11'd1022) begin
                                        memory_write            = 1'b1;
                                        memory_push             = 1'b1;
                                        memory_address_select   = ADDR_SP;
                                        memory_write_src_select = SRC_PC_HI;
                                        state_d                 = CALL_LO;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                OP_RET: begin
                                    if (depth_q >= 11'd2) begin
                                        memory_read           = 1'b1;
                                        memory_pop            = 1'b1;
                                        memory_address_select = ADDR_SP;
                                        state_d               = RET_HI;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                OP_RTI: begin
                                    if (depth_q >= 11'd3) begin
                                        memory_read           = 1'b1;
                                        memory_pop            = 1'b1;
                                        memory_address_select = ADDR_SP;
                                        flags_restore         = 1'b1;
                                        state_d               = RTI_LO;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
                CALL_LO, INT_HI, INT_LO, INT_FL: begin
                    stall                 = 1'b1;
                    memory_write          = 1'b1;
                    memory_push           = 1'b1;
                    memory_address_select = ADDR_SP;
                    unique case (state_q)
                        CALL_LO: begin
                            memory_write_src_select = SRC_PC_LO;
                            state_d                 = IDLE;
                        end
                        INT_HI: begin
                            memory_write_src_select = SRC_PC_HI;
                            state_d                 = INT_LO;
                        end
                        INT_LO: begin
                            memory_write_src_select = SRC_PC_LO;
                            state_d                 = INT_FL;
                        end
                        default: begin
                            memory_write_src_select = SRC_FLAGS;
                            state_d                 = INT_JMP;
                        end
                    endcase
                end
                RET_HI, RTI_LO, RTI_HI: begin
                    stall                 = 1'b1;
                    memory_read           = 1'b1;
                    memory_pop            = 1'b1;
                    memory_address_select = ADDR_SP;
                    unique case (state_q)
                        RET_HI:  state_d = RET_PC;
                        RTI_LO:  state_d = RTI_HI;
                        default: state_d = RTI_PC;
                    endcase
                end
                RET_PC, RTI_PC: begin
                    stall            = 1'b1;
                    pc_choose_memory = 1'b1;
                    state_d          = IDLE;
                end
                INT_JMP: begin
                    stall     = 1'b1;
                    interrupt = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        depth_d = depth_q + {10'd0, memory_push} - {10'd0, memory_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            depth_q <= 11'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign stack_depth = reset ? 11'd0 : depth_q;
    assign stack_error = err_q & ~reset;

endmodule

// File: tb/tb_memory_sequence_controller.sv
// Directed bench for memory_sequence_controller: per-cycle control vectors
// and stack depth against hand-computed values.
module tb_memory_sequence_controller;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        int_req;
    logic        op_ready;
    logic        stall;
    logic        memory_read;
    logic        memory_write;
    logic        memory_push;
    logic        memory_pop;
    logic [1:0]  memory_address_select;
    logic [1:0]  memory_write_src_select;
    logic        pc_choose_memory;
    logic        interrupt;
    logic        flags_restore;
    logic [10:0] stack_depth;
    logic        stack_error;

    int n_tests;
    int n_fail;

    localparam logic [10:0] RDY = 11'h400;
    localparam logic [10:0] STL = 11'h200;
    localparam logic [10:0] RD  = 11'h100;
    localparam logic [10:0] WR  = 11'h080;
    localparam logic [10:0] PU  = 11'h040;
    localparam logic [10:0] PO  = 11'h020;
    localparam logic [10:0] S01 = 11'h008;
    localparam logic [10:0] S10 = 11'h010;
    localparam logic [10:0] S11 = 11'h018;
    localparam logic [10:0] PCM = 11'h004;
    localparam logic [10:0] INT = 11'h002;
    localparam logic [10:0] FLR = 11'h001;
    localparam logic [10:0] NON = 11'h000;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] LDD  = 3'd1;
    localparam logic [2:0] STD  = 3'd2;
    localparam logic [2:0] PUSH = 3'd3;
    localparam logic [2:0] POP  = 3'd4;
    localparam logic [2:0] CALL = 3'd5;
    localparam logic [2:0] RET  = 3'd6;
    localparam logic [2:0] RTI  = 3'd7;

    memory_sequence_controller dut (
        .clk                     (clk),
        .reset                   (reset),
        .op_valid                (op_valid),
        .op_code                 (op_code),
        .int_req                 (int_req),
        .op_ready                (op_ready),
        .stall                   (stall),
        .memory_read             (memory_read),
        .memory_write            (memory_write),
        .memory_push             (memory_push),
        .memory_pop              (memory_pop),
        .memory_address_select   (memory_address_select),
        .memory_write_src_select (memory_write_src_select),
        .pc_choose_memory        (pc_choose_memory),
        .interrupt               (interrupt),
        .flags_restore           (flags_restore),
        .stack_depth             (stack_depth),
        .stack_error             (stack_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance past the edge.
    // ea < 0 leaves the address select unchecked.
    task automatic cyc(input logic rst, input logic v, input logic [2:0] code,
                       input logic ir, input string tag,
                       input logic [10:0] ev, input int ed, input int ea);
        logic [10:0] vec;
        reset    = rst;
        op_valid = v;
        op_code  = code;
        int_req  = ir;
        #1;
        vec = {op_ready, stall, memory_read, memory_write, memory_push,
               memory_pop, memory_write_src_select, pc_choose_memory,
               interrupt, flags_restore};
        check({tag, ".ctl"}, {21'd0, vec}, {21'd0, ev});
        check({tag, ".dep"}, {21'd0, stack_depth}, ed);
        if (ea >= 0)
            check({tag, ".adr"}, {30'd0, memory_address_select}, ea);
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = NOP;
        int_req  = 1'b0;

        cyc(1, 0, NOP, 0, "rst0", NON, 0, 0);
        cyc(1, 1, PUSH, 0, "rst1", NON, 0, 0);
        check("rst_err", {31'd0, stack_error}, 0);
        cyc(0, 0, NOP, 0, "idle0", RDY, 0, 0);

        cyc(0, 1, LDD, 0, "ldd", RDY | RD, 0, 1);
        cyc(0, 1, STD, 0, "std", RDY | WR | S11, 0, 0);
        cyc(0, 1, PUSH, 0, "push", RDY | WR | PU | S11, 0, 2);
        cyc(0, 1, POP, 0, "pop", RDY | RD | PO, 1, 2);
        cyc(0, 1, POP, 0, "pop_empty", RDY, 0, 0);
        cyc(0, 0, NOP, 0, "after_upf", RDY, 0, 0);
        check("upf_err", {31'd0, stack_error}, 1);

        cyc(1, 0, NOP, 0, "rst2", NON, 0, 0);
        cyc(0, 0, NOP, 0, "idle1", RDY, 0, 0);
        check("err_clr", {31'd0, stack_error}, 0);

        cyc(0, 1, CALL, 0, "call0", RDY | WR | PU | S01, 0, -1);
        cyc(0, 1, POP, 1, "call_lo", STL | WR | PU | S10, 1, -1);
        cyc(0, 1, LDD, 1, "int_pend", STL, 2, -1);
        cyc(0, 0, NOP, 0, "int_hi", STL | WR | PU | S01, 2, -1);
        cyc(0, 0, NOP, 0, "int_lo", STL | WR | PU | S10, 3, -1);
        cyc(0, 0, NOP, 0, "int_fl", STL | WR | PU, 4, -1);
        cyc(0, 0, NOP, 0, "int_jmp", STL | INT, 5, -1);
        cyc(0, 0, NOP, 0, "int_done", RDY, 5, 0);

        cyc(0, 1, POP, 0, "pop5", RDY | RD | PO, 5, 2);
        cyc(0, 1, POP, 0, "pop4", RDY | RD | PO, 4, 2);
        cyc(0, 1, RTI, 0, "rti0", RDY | RD | PO | FLR, 3, -1);
        cyc(0, 0, NOP, 0, "rti_lo", STL | RD | PO, 2, -1);
        cyc(0, 0, NOP, 0, "rti_hi", STL | RD | PO, 1, -1);
        cyc(0, 0, NOP, 0, "rti_pc", STL | PCM, 0, -1);

        cyc(0, 1, CALL, 0, "call1", RDY | WR | PU | S01, 0, -1);
        cyc(0, 0, NOP, 0, "call1_lo", STL | WR | PU | S10, 1, -1);
        cyc(0, 1, RET, 0, "ret0", RDY | RD | PO, 2, 2);
        cyc(0, 0, NOP, 0, "ret_hi", STL | RD | PO, 1, 2);
        cyc(0, 0, NOP, 0, "ret_pc", STL | PCM, 0, -1);
        cyc(0, 0, NOP, 0, "ret_done", RDY, 0, 0);
        check("seq_err", {31'd0, stack_error}, 0);

        for (int i = 0; i < 1024; i++)
            cyc(0, 1, PUSH, 0, "fill", RDY | WR | PU | S11, i, 2);
        cyc(0, 1, CALL, 0, "call_full", RDY, 1024, 0);
        cyc(0, 0, NOP, 0, "full_idle", RDY, 1024, 0);
        check("ovf_err", {31'd0, stack_error}, 1);
        cyc(0, 1, PUSH, 0, "push_full", RDY, 1024, 0);
        cyc(0, 0, NOP, 1, "ireq_full", RDY, 1024, 0);
        cyc(0, 1, PUSH, 0, "int_full", STL, 1024, 0);
        cyc(0, 0, NOP, 0, "int_drop", RDY, 1024, 0);

        cyc(0, 1, RET, 0, "ret_full", RDY | RD | PO, 1024, 2);
        cyc(1, 0, NOP, 0, "rst_mid", NON, 0, 0);
        cyc(0, 0, NOP, 0, "post_rst", RDY, 0, 0);
        check("post_err", {31'd0, stack_error}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_sequence_controller.md
MEMORY_SEQUENCE_CONTROLLER -- requirements
Module: memory_sequence_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-002 Port list (name, direction, width, meaning), clock and reset first:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  memory-stage op present.
- op_code  in  3  000 NOP, 001 LDD, 010 STD, 011 PUSH, 100 POP, 101 CALL, 110 RET, 111 RTI.
- int_req  in  1  interrupt request pulse.
- op_ready  out  1  op accepted this cycle.
- stall  out  1  freeze upstream pipeline.
- memory_read  out  1  memory-stage read enable.
- memory_write  out  1  memory-stage write enable.
- memory_push  out  1  memory-stage push enable.
- memory_pop  out  1  memory-stage pop enable.
- memory_address_select  out  2  00 std, 01 ldd, 10 sp.
- memory_write_src_select  out  2  00 flags, 01 pc upper, 10 pc lower, 11 register.
- pc_choose_memory  out  1  next PC from memory shift register.
- interrupt  out  1  force final PC to 0.
- flags_restore  out  1  memory data this cycle is saved flags.
- stack_depth  out  11  words on stack, 0..1024.
- stack_error  out  1  sticky overflow/underflow flag.

Function
REQ-003 All control outputs SHALL be combinational from state, op_valid, op_code and int_pending; selects SHALL default to 00 and enables to 0 when no step is active.
REQ-004 States SHALL be IDLE, CALL_LO, RET_HI, RET_PC, INT_HI, INT_LO, INT_FL, INT_JMP, RTI_LO, RTI_HI, RTI_PC.
REQ-005 op_ready SHALL be 1 only in IDLE with int_pending=0; an op is accepted when op_valid & op_ready, and its first step SHALL be driven in that same cycle.
REQ-006 LDD: read, addr_sel 01; STD: write, addr_sel 00, src 11. Each is a single cycle and the FSM stays in IDLE.
REQ-007 PUSH: write+push, addr_sel 10, src 11. POP: read+pop, addr_sel 10. Each is a single cycle.
REQ-008 CALL, two cycles:
- accept cycle: write+push, src 01.
- CALL_LO: write+push, src 10.
- then IDLE.
REQ-009 RET:
- accept cycle: read+pop, addr_sel 10 (lower word).
- RET_HI: read+pop, addr_sel 10 (upper word).
- RET_PC: pc_choose_memory=1.
- then IDLE.
REQ-010 RTI:
- accept cycle: read+pop with flags_restore=1.
- RTI_LO: read+pop.
- RTI_HI: read+pop.
- RTI_PC: pc_choose_memory=1.
- then IDLE.
REQ-011 int_req SHALL set int_pending at the clock edge; a second int_req while pending SHALL have no effect.
REQ-012 In IDLE with int_pending=1, the FSM SHALL enter INT_HI next edge and clear int_pending. op_ready SHALL be 0 in that cycle.
REQ-013 Interrupt sequence:
- INT_HI: write+push, src 01.
- INT_LO: write+push, src 10.
- INT_FL: write+push, src 00.
- INT_JMP: interrupt=1.
- then IDLE.
REQ-014 stall SHALL be 1 in every non-IDLE state and in IDLE while int_pending=1.
REQ-015 Multi-cycle ops SHALL be stall-protected: op_valid/op_code are ignored outside IDLE.
REQ-016 stack_depth SHALL increment on each edge where memory_push=1 and decrement on each edge where memory_pop=1.
REQ-017 Space checks SHALL be made at accept or INT entry: PUSH needs depth≤1023, CALL ≤1022, INT ≤1021, POP ≥1, RET ≥2, RTI ≥3.
REQ-018 On a failed space check:
- op accepted; no enable asserted; FSM stays in IDLE.
- stack_error set.
- for INT, the request is dropped.
REQ-019 int_req arriving during any sequence SHALL be serviced right after that sequence returns to IDLE, before any new op.

Reset
REQ-020 reset SHALL, at the clock edge, force IDLE, int_pending=0, stack_depth=0 and stack_error=0, including mid-sequence.
REQ-021 With reset=1 all outputs SHALL be 0 except stack_depth=0, and op_ready=0.
REQ-022 In the first cycle after reset, with op_valid=0, all outputs SHALL be 0 except op_ready=1.

Verification
REQ-023 Sequences:
- CALL at depth 0 -> cycle0 push src 01, cycle1 push src 10, stall=1 only in cycle1, depth=2.
- RET at depth 2 -> pops in cycles 0-1, pc_choose_memory=1 in cycle 2, depth=0.
REQ-024 int_req during CALL_LO -> then INT_HI, INT_LO, INT_FL (src 01/10/00), interrupt=1 in INT_JMP; depth +5 total.
REQ-025 RTI at depth 3 -> flags_restore=1 in cycle 0 only; 3 pops; pc_choose_memory in cycle 3; depth=0.
REQ-026 Stack bounds:
- POP at depth 0 -> no memory_pop, stack_error=1, depth stays 0.
- 1024 PUSHes then CALL -> CALL suppressed, error set.
REQ-027 reset asserted during RET_HI -> next cycle IDLE, all enables 0, depth=0, op_ready=1 after release.
REQ-028 Back-to-back LDD, STD, PUSH, POP accepted on consecutive cycles -> stall never 1; depth 0,1,0.
